// File: rtl/wait_state_memory_if.sv
// rtl/wait_state_memory_if.sv - request/response handshake between the CPU bus controller and wait_state_memory
interface wait_state_memory_if #(
  parameter int ADDR_W = 5
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] address;
  logic              busy;
  logic              ready;
  logic              wr_fault;
  logic              parity_err;

  modport master (
    output req, we, address,
    input  busy, ready, wr_fault, parity_err
  );

  modport slave (
    input  req, we, address,
    output busy, ready, wr_fault, parity_err
  );
endinterface

// File: rtl/wait_state_memory.sv
// rtl/wait_state_memory.sv - single-port unified memory with wait states, shared data bus and write-protected instruction region
// Optional read parity checking is enabled by defining WAIT_STATE_MEMORY_PARITY_EN.
module wait_state_memory #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int IMEM_DEPTH  = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  wait_state_memory_if.slave     bus,
  inout  wire  [DATA_W-1:0]      data
);
  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [3:0]        WS_CNT   = 4'(WAIT_STATES);
  localparam logic [ADDR_W:0]   IMEM_LIM = (ADDR_W + 1)'(IMEM_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state, state_nx;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_data;
  logic [3:0]          cnt;
  logic [DATA_W-1:0]   rd_data;
  logic                fault_q;
  logic                perr_q;
  logic                drive_en;
  logic                busy_o, ready_o, wr_fault_o, parity_err_o;

  logic [DATA_W-1:0]   mem [DEPTH];

  // With zero wait states the access commits straight out of IDLE, so the
  // live bus values are used before they reach the latches.
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_data;
  logic                acc_prot;
  logic                commit;
  logic                mem_wr;
  logic                rd_par_bad;

  assign acc_we   = (state == IDLE) ? bus.we      : lat_we;
  assign acc_addr = (state == IDLE) ? bus.address : lat_addr;
  assign acc_data = (state == IDLE) ? data        : lat_data;
  assign acc_prot = {1'b0, acc_addr} < IMEM_LIM;
  assign commit   = (state != RESP) && (state_nx == RESP);
  assign mem_wr   = commit && acc_we && !acc_prot && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.req) state_nx = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT: if (cnt <= 4'd1) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state != IDLE);
    ready_o      = (state == RESP);
    wr_fault_o   = (state == RESP) && fault_q;
    parity_err_o = (state == RESP) && perr_q;
    drive_en     = (state == RESP) && !lat_we;
  end

  assign bus.busy       = busy_o;
  assign bus.ready      = ready_o;
  assign bus.wr_fault   = wr_fault_o;
  assign bus.parity_err = parity_err_o;
  assign data           = drive_en ? rd_data : {DATA_W{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      cnt      <= '0;
      rd_data  <= '0;
      fault_q  <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      if (state == IDLE && bus.req) begin
        lat_we   <= bus.we;
        lat_addr <= bus.address;
        lat_data <= data;
        cnt      <= WS_CNT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        fault_q <= acc_we && acc_prot;
        perr_q  <= !acc_we && rd_par_bad;
        if (!acc_we) rd_data <= mem[acc_addr];
      end
    end
  end

  // Storage is deliberately outside the reset domain: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[acc_addr] <= acc_data;
  end

`ifdef WAIT_STATE_MEMORY_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_wr) par_mem[acc_addr] <= ^acc_data;
  end

  assign rd_par_bad = (^mem[acc_addr]) != par_mem[acc_addr];
`else
  assign rd_par_bad = 1'b0;
`endif

endmodule
